sdfm_sinc_filter: RTL and testbench



---
 rtl/sdfm_sinc_filter.sv | 106 ++++++++++
 tb/tb_sdfm_sinc_filter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sdfm_sinc_filter.sv
// sdfm_sinc_filter: Sinc1/Sinc2/Sinc3 CIC decimator for one SDFM channel.
// The modulator clock and data are synchronised into SYSCLK. One unsigned result is produced per window.
module sdfm_sinc_filter #(
    parameter int DW = 25
) (
    input  logic          SYSCLK,
    input  logic          SYSRSTn,
    input  logic          sd_dsd_in,
    input  logic          sd_clk_in,
    input  logic          reg_en,
    input  logic [1:0]    reg_order,
    input  logic [7:0]    reg_osr,
    output logic [DW-1:0] flt_data,
    output logic          flt_valid
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q;
    logic [2:0]    clk_sync_q;
    logic [1:0]    dsd_sync_q;
    logic [1:0]    order_q;
    logic [7:0]    osr_q;
    logic [7:0]    cnt_q;
    logic [1:0]    settle_q;
    logic          dec_q;
    logic [DW-1:0] int1_q, int2_q, int3_q;
    logic [DW-1:0] dly1_q, dly2_q, dly3_q;
    logic          smp_stb;
    logic          last_smp;
    logic [DW-1:0] bit_d, src_d, c1_d, c2_d, c3_d, y_d;
    logic [1:0]    settle_tgt;

    // Clock and data paths have equal depth, so the data bit lines up with its strobe.
    assign smp_stb = clk_sync_q[1] & ~clk_sync_q[2];

    always_comb begin
        bit_d      = {{(DW-1){1'b0}}, dsd_sync_q[1]};
        last_smp   = smp_stb && (cnt_q == osr_q);
        src_d      = order_q == 2'd0 ? int1_q : order_q == 2'd1 ? int2_q : int3_q;
        c1_d       = src_d - dly1_q;
        c2_d       = c1_d - dly2_q;
        c3_d       = c2_d - dly3_q;
        y_d        = order_q == 2'd0 ? c1_d : order_q == 2'd1 ? c2_d : c3_d;
        settle_tgt = order_q == 2'd0 ? 2'd0 : order_q == 2'd1 ? 2'd1 : 2'd2;
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            state_q    <= IDLE;
            clk_sync_q <= '0;
            dsd_sync_q <= '0;
            order_q    <= '0;
            osr_q      <= '0;
            cnt_q      <= '0;
            settle_q   <= '0;
            dec_q      <= 1'b0;
            int1_q     <= '0;
            int2_q     <= '0;
            int3_q     <= '0;
            dly1_q     <= '0;
            dly2_q     <= '0;
            dly3_q     <= '0;
            flt_data   <= '0;
            flt_valid  <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], sd_clk_in};
            dsd_sync_q <= {dsd_sync_q[0], sd_dsd_in};
            flt_valid  <= 1'b0;
            // Disable takes priority over any strobe in the same cycle.
            if (!reg_en) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                settle_q <= '0;
                dec_q    <= 1'b0;
                int1_q   <= '0;
                int2_q   <= '0;
                int3_q   <= '0;
                dly1_q   <= '0;
                dly2_q   <= '0;
                dly3_q   <= '0;
            end else if (state_q == IDLE) begin
                state_q <= RUN;
                order_q <= reg_order;
                osr_q   <= reg_osr;
            end else begin
                dec_q <= last_smp;
                if (smp_stb) begin
                    int1_q <= int1_q + bit_d;
                    int2_q <= int2_q + int1_q;
                    int3_q <= int3_q + int2_q;
                    cnt_q  <= last_smp ? 8'd0 : cnt_q + 8'd1;
                end
                if (dec_q) begin
                    dly1_q <= src_d;
                    dly2_q <= c1_d;
                    dly3_q <= c2_d;
                    if (settle_q == settle_tgt) begin
                        flt_data  <= y_d;
                        flt_valid <= 1'b1;
                    end else begin
                        settle_q <= settle_q + 2'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sdfm_sinc_filter.sv
// tb_sdfm_sinc_filter: directed stimulus with a result scoreboard for sdfm_sinc_filter.
// SDCLK runs at SYSCLK/8, data changes on its falling edge.
module tb_sdfm_sinc_filter;
    localparam int DW = 25;
    logic          SYSCLK = 1'b0;
    logic          SYSRSTn = 1'b0;
    logic          sd_dsd_in = 1'b0;
    logic          sd_clk_in = 1'b0;
    logic          reg_en = 1'b0;
    logic [1:0]    reg_order = 2'd0;
    logic [7:0]    reg_osr = 8'd0;
    logic [DW-1:0] flt_data;
    logic          flt_valid;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            rise_cyc = 0;
    int            last_vcyc = -1;
    int            pat = 1;
    bit            lat_chk = 1'b0;
    logic          alt = 1'b0;
    logic [DW-1:0] sb[$];

    sdfm_sinc_filter #(.DW(DW)) dut (
        .SYSCLK(SYSCLK),
        .SYSRSTn(SYSRSTn),
        .sd_dsd_in(sd_dsd_in),
        .sd_clk_in(sd_clk_in),
        .reg_en(reg_en),
        .reg_order(reg_order),
        .reg_osr(reg_osr),
        .flt_data(flt_data),
        .flt_valid(flt_valid)
    );

    always #5 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    initial forever begin
        repeat (4) @(negedge SYSCLK);
        sd_clk_in = ~sd_clk_in;
        if (sd_clk_in) rise_cyc = cyc;
        else begin
            alt = ~alt;
            sd_dsd_in = pat == 2 ? alt : (pat == 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int n, input logic [DW-1:0] v);
        for (int i = 0; i < n; i++) sb.push_back(v);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge SYSCLK);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic idle_then_enable(input int gap);
        reg_en = 1'b0;
        repeat (gap) @(negedge SYSCLK);
        reg_en = 1'b1;
    endtask

    always @(negedge SYSCLK) begin
        if (flt_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: flt_valid=1 data=%0d at cycle %0d, expected no result", flt_data, cyc);
            end else begin
                check("result", {7'd0, flt_data}, {7'd0, sb.pop_front()});
            end
            if (lat_chk) begin
                check("rise_to_valid_in_3_to_6", ((cyc - rise_cyc) >= 3 && (cyc - rise_cyc) <= 6), 1);
                if (last_vcyc >= 0) check("valid_spacing", cyc - last_vcyc, 128);
            end
            last_vcyc = cyc;
        end
    end

    initial begin
        #23;
        check("rst_data", {7'd0, flt_data}, 0);
        check("rst_valid", {31'd0, flt_valid}, 0);
        SYSRSTn = 1'b1;
        repeat (40) @(negedge SYSCLK);

        // Sinc1, D=16, all ones: every result 16, spaced 16 SDCLK periods
        pat = 1; reg_order = 2'd0; reg_osr = 8'd15; lat_chk = 1'b1; last_vcyc = -1;
        reg_en = 1'b1;
        push(3, 16);
        drain(600);
        reg_osr = 8'd3;
        push(2, 16);
        drain(400);
        // drop enable during the dec_stb cycle of the next window
        while (cyc < last_vcyc + 127) @(negedge SYSCLK);
        reg_en = 1'b0;
        @(negedge SYSCLK);
        check("dec_drop_valid", {31'd0, flt_valid}, 0);
        check("dec_drop_data", {7'd0, flt_data}, 16);
        lat_chk = 1'b0;
        idle_then_enable(4);
        push(3, 4);
        drain(200);

        // Sinc3, D=256: full scale 2^24, then all zeros
        pat = 1; reg_order = 2'd2; reg_osr = 8'd255;
        idle_then_enable(20);
        push(2, 25'd16777216);
        drain(10000);
        pat = 0;
        idle_then_enable(20);
        push(1, 0);
        drain(8000);

        // Sinc2, D=4, alternating stream in two phases
        pat = 2; reg_order = 2'd1; reg_osr = 8'd3;
        idle_then_enable(20);
        push(3, 8);
        drain(300);
        idle_then_enable(9);
        push(3, 8);
        drain(300);

        // asynchronous reset mid-run
        repeat (10) @(negedge SYSCLK);
        #3 SYSRSTn = 1'b0;
        #1;
        check("async_rst_data", {7'd0, flt_data}, 0);
        check("async_rst_valid", {31'd0, flt_valid}, 0);
        reg_en = 1'b0;
        @(negedge SYSCLK);
        SYSRSTn = 1'b1;
        repeat (60) @(negedge SYSCLK);
        check("post_rst_data", {7'd0, flt_data}, 0);

        // Sinc3, D=8: disable mid-window for 5 cycles
        pat = 1; reg_order = 2'd3; reg_osr = 8'd7;
        idle_then_enable(20);
        push(2, 512);
        drain(600);
        repeat (24) @(negedge SYSCLK);
        reg_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge SYSCLK);
            check("gap_data", {7'd0, flt_data}, 512);
            check("gap_valid", {31'd0, flt_valid}, 0);
        end
        reg_en = 1'b1;
        repeat (140) @(negedge SYSCLK);
        check("settle_hold_data", {7'd0, flt_data}, 512);
        push(2, 512);
        drain(600);

        reg_en = 1'b0;
        repeat (10) @(negedge SYSCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
